mult_arbiter: RTL

Round-robin arbiter and sequencer that shares one multi-cycle multiplier between N_REQ requesters, such as several complex-multiplier controllers.
- Grants one requester at a time and latches its operands.
- Issues the multiplier start pulse and waits on the multiplier's ready level.
- Returns the product to the granted requester with a one-cycle done pulse.

---
 rtl/mult_arb_pkg.sv | 17 +
 rtl/mult_arbiter_if.sv | 30 +++
 rtl/mult_arbiter_rr_picker.sv | 34 +++
 rtl/mult_arbiter.sv | 124 ++++++++++++
 4 files changed

// File: rtl/mult_arb_pkg.sv
// Shared constants for the multiplier arbiter: FSM state encoding and a
// width helper for the round-robin pointer and watchdog counter.
package mult_arb_pkg;

    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] ISSUE = 2'b01;
    localparam logic [1:0] WAIT  = 2'b10;
    localparam logic [1:0] DONE  = 2'b11;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/mult_arbiter_if.sv
// Requester and multiplier signals of the shared-multiplier arbiter.
// slave = arbiter side, master = requesters plus multiplier side.
interface mult_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 16
);
    logic [N_REQ-1:0]       req;
    logic [N_REQ*WIDTH-1:0] opA;
    logic [N_REQ*WIDTH-1:0] opB;
    logic [N_REQ-1:0]       grant;
    logic [N_REQ-1:0]       done;
    logic [2*WIDTH-1:0]     product;
    logic                   err;
    logic                   busy;
    logic                   mulStart;
    logic [WIDTH-1:0]       mulA;
    logic [WIDTH-1:0]       mulB;
    logic                   mulReady;
    logic [2*WIDTH-1:0]     mulResult;

    modport slave (
        input  req, opA, opB, mulReady, mulResult,
        output grant, done, product, err, busy, mulStart, mulA, mulB
    );

    modport master (
        output req, opA, opB, mulReady, mulResult,
        input  grant, done, product, err, busy, mulStart, mulA, mulB
    );
endinterface

// File: rtl/mult_arbiter_rr_picker.sv
// Combinational round-robin picker: searches req starting one past ptr,
// wrapping modulo N_REQ, and returns the first hit as one-hot and index.
module rr_picker #(
    parameter int N_REQ = 4,
    parameter int PW    = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PW-1:0]    ptr,
    output logic [N_REQ-1:0] winner,
    output logic [PW-1:0]    idx,
    output logic             found
);

    function automatic logic [PW-1:0] wrapIdx(input logic [PW-1:0] p, input int step);
        int s;
        s = (int'(p) + step) % N_REQ;
        return PW'(s);
    endfunction

    always_comb begin
        winner = '0;
        idx    = '0;
        found  = 1'b0;
        // Candidate ptr itself is visited last (step N_REQ), giving it lowest priority.
        for (int i = 1; i <= N_REQ; i++) begin
            if (!found && req[wrapIdx(ptr, i)]) begin
                found = 1'b1;
                idx   = wrapIdx(ptr, i);
            end
        end
        if (found) winner[idx] = 1'b1;
    end

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin arbiter/sequencer sharing one multi-cycle multiplier among N_REQ requesters.
// Optional WAIT-state watchdog with err pulse: define MULT_ARB_TIMEOUT_EN.
module mult_arbiter
    import mult_arb_pkg::*;
#(
    parameter int N_REQ          = 4,
    parameter int WIDTH          = 16,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic           clk,
    input  logic           rst,
    mult_arbiter_if.slave  bus
);

    localparam int PW = clog2(N_REQ);

    logic [1:0]         state;
    logic [PW-1:0]      ptr;
    logic [PW-1:0]      pickIdx;
    logic [N_REQ-1:0]   pickOneHot;
    logic               anyReq;
    logic [N_REQ-1:0]   grantReg;
    logic [WIDTH-1:0]   mulAReg;
    logic [WIDTH-1:0]   mulBReg;
    logic [2*WIDTH-1:0] productReg;
    logic               firstWait;
    logic               resultOk;
    logic               timeoutHit;

    rr_picker #(
        .N_REQ (N_REQ),
        .PW    (PW)
    ) picker (
        .req    (bus.req),
        .ptr    (ptr),
        .winner (pickOneHot),
        .idx    (pickIdx),
        .found  (anyReq)
    );

    // Ready may still be high from the previous op during the first WAIT cycle.
    assign resultOk = (state == WAIT) && !firstWait && bus.mulReady;

`ifdef MULT_ARB_TIMEOUT_EN
    localparam int CW = clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] waitCnt;
    logic          timedOut;

    assign timeoutHit = (state == WAIT) && (waitCnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            waitCnt  <= '0;
            timedOut <= 1'b0;
        end else begin
            if (state == WAIT) waitCnt <= waitCnt + CW'(1);
            else               waitCnt <= '0;

            if (state == WAIT)      timedOut <= timeoutHit && !resultOk;
            else if (state == DONE) timedOut <= 1'b0;
        end
    end

    assign bus.err = (state == DONE) && timedOut;
`else
    logic [31:0] unusedTimeout;
    assign unusedTimeout = TIMEOUT_CYCLES;
    assign timeoutHit    = 1'b0;
    assign bus.err       = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            ptr        <= PW'(N_REQ - 1);
            grantReg   <= '0;
            mulAReg    <= '0;
            mulBReg    <= '0;
            productReg <= '0;
            firstWait  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // A busy multiplier (e.g. after a mid-op reset) blocks new grants.
                    if (anyReq && bus.mulReady) begin
                        state    <= ISSUE;
                        grantReg <= pickOneHot;
                        ptr      <= pickIdx;
                        mulAReg  <= bus.opA[pickIdx*WIDTH +: WIDTH];
                        mulBReg  <= bus.opB[pickIdx*WIDTH +: WIDTH];
                    end
                end
                ISSUE: begin
                    state     <= WAIT;
                    firstWait <= 1'b1;
                end
                WAIT: begin
                    firstWait <= 1'b0;
                    if (resultOk) begin
                        productReg <= bus.mulResult;
                        state      <= DONE;
                    end else if (timeoutHit) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    grantReg <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.grant    = grantReg;
    assign bus.done     = (state == DONE) ? grantReg : '0;
    assign bus.product  = productReg;
    assign bus.busy     = (state != IDLE);
    assign bus.mulStart = (state == ISSUE);
    assign bus.mulA     = mulAReg;
    assign bus.mulB     = mulBReg;

endmodule
